// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters (CPU port A, DMA port B),
// the dump trigger and the single-port dmem RAM.
`timescale 1ns/1ps

interface dmem_arbiter_if;
    // CPU port A
    logic        a_req;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wd;
    logic [31:0] a_rd;
    logic        a_stall;
    // DMA port B
    logic        b_valid;
    logic        b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wd;
    logic        b_ready;
    logic [31:0] b_rd;
    // Image dump trigger
    logic        dump_req;
    logic        dump_start;
    logic        dump_busy;
    // RAM side
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    // Status
    logic        addr_err;

    // Arbiter view
    modport slave (
        input  a_req, a_we, a_addr, a_wd,
        output a_rd, a_stall,
        input  b_valid, b_we, b_addr, b_wd,
        output b_ready, b_rd,
        input  dump_req,
        output dump_start, dump_busy,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd,
        output addr_err
    );

    // Requester / RAM view
    modport master (
        output a_req, a_we, a_addr, a_wd,
        input  a_rd, a_stall,
        output b_valid, b_we, b_addr, b_wd,
        input  b_ready, b_rd,
        output dump_req,
        input  dump_start, dump_busy,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd,
        input  addr_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has fixed priority, the DMA is forced through after
// MAX_WAIT consecutive refusals. Out-of-range accesses are squashed and flagged
// sticky. A dump request drains the memory for one cycle before pulsing the
// RAM dump trigger, so the image is never taken mid-write.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int unsigned DEPTH    = 129600,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DUMP  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
    localparam logic [31:0]      DEPTH_C    = 32'(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             dump_req_q, dump_req_d;   // previous dump_req level
    logic             dump_arm_q, dump_arm_d;   // dump_req seen low since reset
    logic             addr_err_q, addr_err_d;

    logic             grant_a, grant_b;
    logic             oob;
    logic             dump_rise;
    logic             mem_we;
    logic [31:0]      mem_addr, mem_wd;
    logic [31:0]      a_rd, b_rd;

    // Grant decision: CPU first unless the DMA has waited MAX_WAIT cycles.
    // NOTE: every signal written in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (reset_n && state_q == RUN) begin
            if (bus.a_req && wait_cnt_q < MAX_WAIT_C) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    // RAM mux and read-data return for the granted port, with bounds squash.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = 32'd0;
        mem_wd   = 32'd0;
        oob      = 1'b0;
        a_rd     = 32'd0;
        b_rd     = 32'd0;
        if (grant_a) begin
            mem_addr = bus.a_addr;
            mem_wd   = bus.a_wd;
            oob      = (bus.a_addr >= DEPTH_C);
            mem_we   = bus.a_we && !oob;
            a_rd     = oob ? 32'd0 : bus.mem_rd;
        end else if (grant_b) begin
            mem_addr = bus.b_addr;
            mem_wd   = bus.b_wd;
            oob      = (bus.b_addr >= DEPTH_C);
            mem_we   = bus.b_we && !oob;
            b_rd     = oob ? 32'd0 : bus.mem_rd;
        end
    end

    // Next-state: dump sequencer, starvation counter, edge detect, error flag.
    always_comb begin
        state_d    = state_q;
        dump_req_d = bus.dump_req;
        dump_arm_d = dump_arm_q | ~bus.dump_req;
        addr_err_d = addr_err_q | ((grant_a | grant_b) & oob);
        // A level still high from before reset must fall first to count as an edge.
        dump_rise  = bus.dump_req & ~dump_req_q & dump_arm_q;

        case (state_q)
            RUN:     if (dump_rise) state_d = DRAIN;
            DRAIN:   state_d = DUMP;
            DUMP:    state_d = RUN;
            default: state_d = RUN;
        endcase

        if (bus.b_valid && !grant_b) begin
            wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
        end
    end

    // State registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            dump_req_q <= 1'b0;
            dump_arm_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            dump_req_q <= dump_req_d;
            dump_arm_q <= dump_arm_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wd     = mem_wd;
    assign bus.a_rd       = a_rd;
    assign bus.b_rd       = b_rd;
    assign bus.a_stall    = reset_n && bus.a_req && !grant_a;
    assign bus.b_ready    = grant_b;
    assign bus.dump_start = reset_n && (state_q == DUMP);
    assign bus.dump_busy  = reset_n && (state_q != RUN);
    assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cycle table, then randomized traffic
// checked against a cycle-level reference model with a shadow memory.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    localparam int unsigned DEPTH    = 129600;
    localparam int unsigned MAX_WAIT = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // RAM model; out-of-range reads return junk so squashing is observable.
    logic [31:0] ram [0:DEPTH-1];
    assign bus.mem_rd = (bus.mem_addr < DEPTH) ? ram[bus.mem_addr[16:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1 && bus.mem_addr < DEPTH) ram[bus.mem_addr[16:0]] = bus.mem_wd;
    end

    typedef struct {
        logic        rst_n, a_req, a_we;
        logic [31:0] a_addr, a_wd;
        logic        b_valid, b_we;
        logic [31:0] b_addr, b_wd;
        logic        dump;
        logic        x_stall, x_ready, x_we, x_start, x_busy, x_err;
        logic [31:0] x_ard, x_brd;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int          phase;        // 0 normal, 1 draining, 2 dumping
    int          refused;      // consecutive cycles the DMA was turned away
    bit          prev_dump;
    bit          seen_low;     // dump_req observed low since reset
    bit          err;
    logic [31:0] shadow [logic [31:0]];
    bit          m_served, m_write, m_oob, m_dma;
    logic [31:0] m_addr, m_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic rst, logic areq, logic awe, logic [31:0] aaddr, logic [31:0] awd,
                                logic bval, logic bwe, logic [31:0] baddr, logic [31:0] bwd, logic dmp,
                                logic xs, logic xr, logic xw, logic xst, logic xbz, logic xe,
                                logic [31:0] xard, logic [31:0] xbrd);
        vec_t v;
        v.rst_n = rst; v.a_req = areq; v.a_we = awe; v.a_addr = aaddr; v.a_wd = awd;
        v.b_valid = bval; v.b_we = bwe; v.b_addr = baddr; v.b_wd = bwd; v.dump = dmp;
        v.x_stall = xs; v.x_ready = xr; v.x_we = xw; v.x_start = xst; v.x_busy = xbz; v.x_err = xe;
        v.x_ard = xard; v.x_brd = xbrd;
        return v;
    endfunction

    function automatic logic [31:0] rd_shadow(logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : 32'h0;
    endfunction

    // Model outputs for the current cycle, from the rules as stated.
    task automatic model_predict(inout vec_t e);
        bit cpu, dma;
        m_served = 0; m_write = 0; m_oob = 0; m_dma = 0; m_addr = 0; m_wd = 0;
        e.x_err = err; e.x_stall = 0; e.x_ready = 0; e.x_we = 0;
        e.x_start = 0; e.x_busy = 0; e.x_ard = 0; e.x_brd = 0;
        if (!e.rst_n) return;
        if (phase != 0) begin
            e.x_stall = e.a_req;
            e.x_busy  = 1;
            e.x_start = (phase == 2);
            return;
        end
        cpu = e.a_req && refused < MAX_WAIT;
        dma = !cpu && e.b_valid;
        if (cpu || dma) begin
            m_served = 1;
            m_dma    = dma;
            m_addr   = cpu ? e.a_addr : e.b_addr;
            m_wd     = cpu ? e.a_wd : e.b_wd;
            m_oob    = !(m_addr < DEPTH);
            m_write  = (cpu ? e.a_we : e.b_we) && !m_oob;
            e.x_we   = m_write;
            if (cpu) e.x_ard = m_oob ? 32'h0 : rd_shadow(m_addr);
            else     e.x_brd = m_oob ? 32'h0 : rd_shadow(m_addr);
        end
        e.x_stall = e.a_req && !cpu;
        e.x_ready = dma;
    endtask

    // Model state update at the clock edge (uses the m_* values of this cycle).
    task automatic model_commit(input vec_t v);
        if (!v.rst_n) begin
            phase = 0; refused = 0; prev_dump = 0; seen_low = 0; err = 0;
            return;
        end
        if (m_write) shadow[m_addr] = m_wd;
        if (m_served && m_oob) err = 1;
        refused = (v.b_valid && !m_dma) ? ((refused < MAX_WAIT) ? refused + 1 : refused) : 0;
        case (phase)
            0: if (v.dump && !prev_dump && seen_low) phase = 1;
            1: phase = 2;
            default: phase = 0;
        endcase
        prev_dump = v.dump;
        if (!v.dump) seen_low = 1;
    endtask

    task automatic drive(input vec_t v);
        reset_n      = v.rst_n;
        bus.a_req    = v.a_req;   bus.a_we  = v.a_we;  bus.a_addr = v.a_addr; bus.a_wd = v.a_wd;
        bus.b_valid  = v.b_valid; bus.b_we  = v.b_we;  bus.b_addr = v.b_addr; bus.b_wd = v.b_wd;
        bus.dump_req = v.dump;
    endtask

    // One clock: drive at negedge, compare mid-cycle, advance model at posedge.
    task automatic step(input vec_t v, input bit use_tbl, input string tag);
        vec_t e, x;
        @(negedge clk);
        drive(v);
        #1;
        e = v;
        model_predict(e);
        x = use_tbl ? v : e;
        check({tag, ".a_stall"},    bus.a_stall,    x.x_stall);
        check({tag, ".b_ready"},    bus.b_ready,    x.x_ready);
        check({tag, ".mem_we"},     bus.mem_we,     x.x_we);
        check({tag, ".dump_start"}, bus.dump_start, x.x_start);
        check({tag, ".dump_busy"},  bus.dump_busy,  x.x_busy);
        check({tag, ".addr_err"},   bus.addr_err,   x.x_err);
        check({tag, ".a_rd"},       bus.a_rd,       x.x_ard);
        check({tag, ".b_rd"},       bus.b_rd,       x.x_brd);
        if (!use_tbl && m_served) begin
            check({tag, ".mem_addr"}, bus.mem_addr, m_addr);
            if (m_write) check({tag, ".mem_wd"}, bus.mem_wd, m_wd);
        end
        @(posedge clk);
        model_commit(v);
    endtask

    function automatic logic [31:0] pick_addr();
        int r = $urandom_range(0, 19);
        if (r == 0) return DEPTH + $urandom_range(0, 3);
        if (r == 1) return $urandom | 32'h8000_0000;
        if (r == 2) return DEPTH - 1;
        return $urandom_range(0, 15);
    endfunction

    initial begin
        vec_t v;
        logic dump_lvl;
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'h0;

        // Power-up reset cycle, not checked (flops unknown before first edge).
        v = mk(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0, 0,0);
        drive(v);
        @(posedge clk);
        model_commit(v);

        // Reset forces outputs off even with both ports requesting writes.
        tbl.push_back(mk(0, 1,1,20,32'h1111, 1,1,21,32'h2222, 0, 0,0,0,0,0,0, 0,0));
        // CPU write then read back.
        tbl.push_back(mk(1, 1,1,10,32'hDEADBEEF, 0,0,0,0, 0, 0,0,1,0,0,0, 0,0));
        tbl.push_back(mk(1, 1,0,10,0, 0,0,0,0, 0, 0,0,0,0,0,0, 32'hDEADBEEF,0));
        tbl.push_back(mk(1, 1,0,20,0, 0,0,0,0, 0, 0,0,0,0,0,0, 0,0));
        // DMA burst writes data=addr, CPU reads back.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 0,0,0,0, 1,1,i,i, 0, 0,1,1,0,0,0, 0,0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1,0,i,0, 0,0,0,0, 0, 0,0,0,0,0,0, i,0));
        // Contention: 4 CPU grants then one forced DMA grant, repeating.
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) tbl.push_back(mk(1, 1,0,3,0, 1,0,5,0, 0, 1,1,0,0,0,0, 0,5));
            else            tbl.push_back(mk(1, 1,0,3,0, 1,0,5,0, 0, 0,0,0,0,0,0, 3,0));
        end
        // A dropped DMA request clears the starvation count.
        tbl.push_back(mk(1, 1,0,3,0, 1,0,5,0, 0, 0,0,0,0,0,0, 3,0));
        tbl.push_back(mk(1, 1,0,3,0, 1,0,5,0, 0, 0,0,0,0,0,0, 3,0));
        tbl.push_back(mk(1, 1,0,3,0, 0,0,0,0, 0, 0,0,0,0,0,0, 3,0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1, 1,0,3,0, 1,0,5,0, 0, 0,0,0,0,0,0, 3,0));
        tbl.push_back(mk(1, 1,0,3,0, 1,0,5,0, 0, 1,1,0,0,0,0, 0,5));
        // Last legal word.
        tbl.push_back(mk(1, 1,1,DEPTH-1,32'h77, 0,0,0,0, 0, 0,0,1,0,0,0, 0,0));
        tbl.push_back(mk(1, 1,0,DEPTH-1,0, 0,0,0,0, 0, 0,0,0,0,0,0, 32'h77,0));
        // Out of range: squashed, served, sticky error from next cycle.
        tbl.push_back(mk(1, 1,1,DEPTH,1, 0,0,0,0, 0, 0,0,0,0,0,0, 0,0));
        tbl.push_back(mk(1, 1,0,200000,0, 0,0,0,0, 0, 0,0,0,0,0,1, 0,0));
        tbl.push_back(mk(1, 1,0,32'h8000_000A,0, 0,0,0,0, 0, 0,0,0,0,0,1, 0,0));
        tbl.push_back(mk(1, 0,0,0,0, 1,0,32'hFFFF_FFFF,0, 0, 0,1,0,0,0,1, 0,0));
        tbl.push_back(mk(1, 0,0,0,0, 1,1,DEPTH,5, 0, 0,1,0,0,0,1, 0,0));
        tbl.push_back(mk(1, 1,0,10,0, 0,0,0,0, 0, 0,0,0,0,0,1, 32'hDEADBEEF,0));
        // Dump with a same-cycle CPU write; held level does not retrigger.
        tbl.push_back(mk(1, 1,1,5,32'h55, 0,0,0,0, 1, 0,0,1,0,0,1, 5,0));
        tbl.push_back(mk(1, 1,0,5,0, 1,1,6,99, 1, 1,0,0,0,1,1, 0,0));
        tbl.push_back(mk(1, 1,0,5,0, 1,1,6,99, 1, 1,0,0,1,1,1, 0,0));
        tbl.push_back(mk(1, 1,0,5,0, 0,0,0,0, 1, 0,0,0,0,0,1, 32'h55,0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,1, 0,0));
        // Reset during DRAIN aborts the dump; held level needs a new edge.
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 0,0,0,0,0,1, 0,0));
        tbl.push_back(mk(0, 1,1,7,32'h12, 0,0,0,0, 1, 0,0,0,0,0,1, 0,0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 0,0,0,0,0,0, 0,0));
        tbl.push_back(mk(1, 1,0,7,0, 0,0,0,0, 1, 0,0,0,0,0,0, 7,0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0, 0,0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 0,0,0,0,0,0, 0,0));
        tbl.push_back(mk(1, 1,0,7,0, 0,0,0,0, 1, 1,0,0,0,1,0, 0,0));
        tbl.push_back(mk(1, 1,0,7,0, 0,0,0,0, 1, 1,0,0,1,1,0, 0,0));
        tbl.push_back(mk(1, 1,0,7,0, 0,0,0,0, 1, 0,0,0,0,0,0, 7,0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0, 0,0));

        foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Randomized traffic against the reference model.
        dump_lvl = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 15) == 0) dump_lvl = ~dump_lvl;
            v = mk($urandom_range(0, 149) != 0,
                   $urandom_range(0, 3) != 0, 1'($urandom), pick_addr(), $urandom,
                   $urandom_range(0, 2) != 0, 1'($urandom), pick_addr(), $urandom,
                   dump_lvl, 0,0,0,0,0,0, 0,0);
            step(v, 1'b0, $sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (word-addressed, 129600 words, 32-bit, combinational read, write on posedge clk) between two requesters: the pipeline CPU (port A) and the image-streaming DMA engine (port B).
- Fixed priority goes to the CPU. A starvation counter guarantees the DMA a slot.
- Also bounds-checks addresses and sequences the image-dump trigger so the memory is never dumped mid-write.
- Sits between the pipeline MEM stage / DMA engine and the dmem RAM.

Parameters:
- DEPTH, 129600, number of valid words; legal addresses 0..DEPTH-1.
- MAX_WAIT, 4, consecutive cycles a DMA request may be refused before it is forced through.
- CNT_W, 3, width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset_n  in  1  synchronous active-low reset.
- a_req  in  1  CPU access request this cycle.
- a_we  in  1  CPU write enable (qualified by a_req).
- a_addr  in  32  CPU word address.
- a_wd  in  32  CPU write data.
- a_rd  out  32  CPU read data (combinational).
- a_stall  out  1  CPU access not served this cycle; pipeline must hold.
- b_valid  in  1  DMA request valid.
- b_we  in  1  DMA write enable.
- b_addr  in  32  DMA word address.
- b_wd  in  32  DMA write data.
- b_ready  out  1  DMA request accepted this cycle (valid&ready = transfer).
- b_rd  out  32  DMA read data, valid when b_valid&b_ready&!b_we.
- dump_req  in  1  request to dump memory image (level or pulse; edge-detected).
- dump_start  out  1  one-cycle pulse to the RAM dump trigger.
- dump_busy  out  1  dump sequence in progress.
- mem_we  out  1  RAM write enable.
- mem_addr  out  32  RAM address.
- mem_wd  out  32  RAM write data.
- mem_rd  in  32  RAM read data.
- addr_err  out  1  sticky: an out-of-range access was attempted; cleared only by reset.

Behaviour:
- Reset (reset_n=0 at posedge): state=RUN, wait_cnt=0, dump_start=0, dump_busy=0, addr_err=0, dump_req edge register=0.
- While reset_n=0, the combinational outputs are forced: mem_we=0, a_stall=0, b_ready=0.
- Reset mid-dump aborts the dump with no pulse.
- Grant is combinational in the same cycle. Read data is returned in the same cycle (a_rd=b_rd=mem_rd). A write commits at the next posedge.
- Grant rules in RUN:
  - a_req=1 and wait_cnt<MAX_WAIT: grant A, a_stall=0, b_ready=0.
  - Otherwise if b_valid: grant B, b_ready=1, a_stall=a_req.
  - No requester: mem_we=0, mem_addr=0.
- wait_cnt:
  - Increments when b_valid=1 and B is not granted; saturates at MAX_WAIT.
  - Clears when B is granted or b_valid=0.
- mem_addr/mem_wd/mem_we are muxed from the granted port.
- Out-of-range access (addr>=DEPTH) by the granted port:
  - mem_we forced 0; returned read data forced 0.
  - The access still completes: no stall, ready still given.
  - addr_err set at the next posedge.
- A port never sees the other port's read data; a non-granted port's rd is 0.
- Dump sequence, on a rising edge of dump_req detected in RUN:
  - RUN -> DRAIN: both ports blocked (a_stall=a_req, b_ready=0, mem_we=0) for exactly one cycle, letting the last granted write land.
  - DRAIN -> DUMP: dump_start=1 for one cycle, ports still blocked.
  - DUMP -> RUN.
  - dump_busy=1 in DRAIN and DUMP.
  - dump_req edges arriving during DRAIN/DUMP are ignored. The edge register still tracks, so a held level does not retrigger.
- The dump trigger edge and a same-cycle access in RUN: the access is served that cycle; DRAIN starts next cycle.
- Widths: addresses are compared as unsigned 32-bit against DEPTH; no truncation before the check.

Test Plan:
- CPU only: a_req=1, a_we=1, a_addr=10, a_wd=0xDEADBEEF; next cycle read addr 10 -> a_rd=0xDEADBEEF, a_stall=0 both cycles, mem_we=1 only in the first.
- Contention: a_req and b_valid held high continuously, MAX_WAIT=4 -> A granted 4 cycles, B granted on the 5th with a_stall=1; the pattern repeats every 5 cycles.
- DMA only burst: b_valid=1 writing addresses 0..7 with data=addr -> b_ready=1 every cycle. Readback via port A returns 0..7.
- Bounds: a_we=1, a_addr=129600 -> mem_we=0, a_stall=0, addr_err=1 next cycle and stays 1. Read at 200000 -> a_rd=0.
- Dump: write addr 5=0x55 in cycle N with a dump_req rise in cycle N -> DRAIN N+1, dump_start=1 at N+2 only, dump_busy N+1..N+2. CPU req stalled N+1..N+2, served N+3.
- Reset in DRAIN: reset_n=0 -> dump_start never pulses, dump_busy=0, state RUN. Held dump_req after reset causes no dump until it falls and rises again.
